flt_addsub_seq: RTL and testbench

- Parametrised multi-cycle IEEE-style floating-point add/subtract unit that replaces the software float-add program with a hardware coprocessor.
- Attaches beside the processor datapath, which supplies operands from data memory and waits on its done flag.
- Generalises the half-precision add: configurable exponent and mantissa widths, true subtraction, round-to-nearest-even, and special-value handling.

---
 rtl/flt_pkg.sv | 42 ++++
 rtl/flt_round_rne.sv | 21 ++
 rtl/flt_addsub_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_flt_addsub_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/flt_pkg.sv
// Shared types and constant helpers for the sequential float add/subtract unit.
// Word helpers return 64-bit patterns; callers slice them to their own word width.
package flt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    CL_ZERO,
    CL_NORM,
    CL_INF,
    CL_NAN
  } cls_t;

  function automatic int flt_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] flt_inf(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  function automatic logic [63:0] flt_nan(input int exp_w, input int man_w);
    return flt_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

  // Subnormals classify as zero so they flush with their sign kept.
  function automatic cls_t flt_class(input logic exp_zero, input logic exp_ones,
                                     input logic frac_zero);
    if (exp_zero) return CL_ZERO;
    if (exp_ones) return frac_zero ? CL_INF : CL_NAN;
    return CL_NORM;
  endfunction

endpackage

// File: rtl/flt_round_rne.sv
// Round-to-nearest-even on a {hidden, frac, G, R, S} mantissa.
// On a mantissa carry the fraction is returned already renormalised (all zero).
module flt_round_rne #(
  parameter int MAN_W = 10
) (
  input  logic [MAN_W+3:0] mant,
  output logic [MAN_W-1:0] frac,
  output logic             carry,
  output logic             lost
);

  logic             up;
  logic [MAN_W+1:0] inc;

  assign up    = mant[2] & (mant[1] | mant[0] | mant[3]);
  assign inc   = {1'b0, mant[MAN_W+3:3]} + (MAN_W+2)'(up);
  assign carry = inc[MAN_W+1];
  assign frac  = carry ? inc[MAN_W:1] : inc[MAN_W-1:0];
  assign lost  = |mant[2:0];

endmodule

// File: rtl/flt_addsub_seq.sv
// Multi-cycle floating-point add/subtract coprocessor with RNE rounding and
// special-value handling; one operation in flight, result held until the next done.
//
// state  | meaning
// IDLE   | waiting for start; operands captured on the accepting edge
// UNPACK | classify operands; specials go straight to DONE
// ALIGN  | order by magnitude, right-shift smaller mantissa with sticky
// ADD    | add/subtract magnitudes; exact zero goes to DONE
// NORM   | one shift per cycle until the hidden bit is set
// ROUND  | round-to-nearest-even, overflow to infinity
// DONE   | result valid, done pulse
module flt_addsub_seq
  import flt_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 op_sub,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 done,
  output logic                 busy,
  output logic                 ovf,
  output logic                 inexact
);

  localparam int FW = EXP_W + MAN_W + 1;
  localparam int MW = MAN_W + 4;
  localparam int XW = EXP_W + 1;
  localparam logic [63:0]    INF64    = flt_inf(EXP_W, MAN_W);
  localparam logic [63:0]    NAN64    = flt_nan(EXP_W, MAN_W);
  localparam logic [FW-1:0]  INF_W    = INF64[FW-1:0];
  localparam logic [FW-1:0]  NAN_W    = NAN64[FW-1:0];
  localparam logic [XW-1:0]  EXP_ONES = {1'b0, {EXP_W{1'b1}}};

  state_t state_q, state_d;

  logic [FW-1:0]    op_a_q, op_b_q;
  logic             sub_q, sign_q, eff_sub_q;
  logic [XW-1:0]    exp_q;
  logic [MW-1:0]    big_q, small_q;
  logic [MW:0]      sum_q, sum_d, norm_right;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, e_big, e_small, diff;
  logic [MAN_W-1:0] fa, fb;
  cls_t             ca, cb;
  logic             special, a_big, sign_big;
  logic [FW-1:0]    special_res;
  logic [MW-1:0]    m_big, m_small, m_shift;
  logic [2*MW-1:0]  ext;

  logic [MAN_W-1:0] rnd_frac;
  logic             rnd_carry, rnd_lost, rnd_ovf;
  logic [XW-1:0]    exp_r;
  logic [FW-1:0]    rnd_res;

  logic             fin_load, fin_ovf, fin_inx;
  logic [FW-1:0]    fin_res;

  assign sa = op_a_q[FW-1];
  assign sb = op_b_q[FW-1] ^ sub_q;
  assign ea = op_a_q[FW-2:MAN_W];
  assign eb = op_b_q[FW-2:MAN_W];
  assign fa = op_a_q[MAN_W-1:0];
  assign fb = op_b_q[MAN_W-1:0];
  assign ca = flt_class(ea == '0, &ea, fa == '0);
  assign cb = flt_class(eb == '0, &eb, fb == '0);
  assign special = (ca != CL_NORM) || (cb != CL_NORM);

  always_comb begin
    if (ca == CL_NAN || cb == CL_NAN || (ca == CL_INF && cb == CL_INF && sa != sb))
      special_res = NAN_W;
    else if (ca == CL_INF)
      special_res = {sa, INF_W[FW-2:0]};
    else if (cb == CL_INF)
      special_res = {sb, INF_W[FW-2:0]};
    else if (ca == CL_ZERO && cb == CL_ZERO)
      special_res = {sa & sb, {(FW-1){1'b0}}};
    else if (ca == CL_ZERO)
      special_res = {sb, op_b_q[FW-2:0]};
    else
      special_res = op_a_q;
  end

  assign a_big = {ea, fa} >= {eb, fb};

  always_comb begin
    if (a_big) begin
      sign_big = sa;
      e_big    = ea;
      e_small  = eb;
      m_big    = {1'b1, fa, 3'b000};
      m_small  = {1'b1, fb, 3'b000};
    end else begin
      sign_big = sb;
      e_big    = eb;
      e_small  = ea;
      m_big    = {1'b1, fb, 3'b000};
      m_small  = {1'b1, fa, 3'b000};
    end
    diff = e_big - e_small;
    ext  = {m_small, {MW{1'b0}}} >> diff;
    // Beyond the G/R/S window only the sticky bit survives.
    if (diff > EXP_W'(MW - 1))
      m_shift = {{(MW-1){1'b0}}, 1'b1};
    else
      m_shift = {ext[2*MW-1:MW+1], ext[MW] | (|ext[MW-1:0])};
  end

  assign sum_d = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                           : ({1'b0, big_q} + {1'b0, small_q});
  assign norm_right = {1'b0, sum_q[MW:2], sum_q[1] | sum_q[0]};

  flt_round_rne #(.MAN_W(MAN_W)) u_round (
    .mant  (sum_q[MW-1:0]),
    .frac  (rnd_frac),
    .carry (rnd_carry),
    .lost  (rnd_lost)
  );

  assign exp_r   = exp_q + XW'(rnd_carry);
  assign rnd_ovf = exp_r >= EXP_ONES;
  assign rnd_res = rnd_ovf ? {sign_q, INF_W[FW-2:0]}
                           : {sign_q, exp_r[EXP_W-1:0], rnd_frac};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fin_load = 1'b0;
    fin_res  = '0;
    fin_ovf  = 1'b0;
    fin_inx  = 1'b0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_UNPACK;
      ST_UNPACK: begin
        if (special) begin
          state_d  = ST_DONE;
          fin_load = 1'b1;
          fin_res  = special_res;
        end else begin
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN:  state_d = ST_ADD;
      ST_ADD: begin
        if (sum_d == '0) begin
          state_d  = ST_DONE;
          fin_load = 1'b1;
        end else if (sum_d[MW] || !sum_d[MW-1]) begin
          state_d = ST_NORM;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_NORM: begin
        if (sum_q[MW]) begin
          state_d = ST_ROUND;
        end else if (exp_q <= XW'(1)) begin
          state_d  = ST_DONE;
          fin_load = 1'b1;
          fin_res  = {sign_q, {(FW-1){1'b0}}};
          fin_inx  = 1'b1;
        end else if (sum_q[MW-2]) begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d  = ST_DONE;
        fin_load = 1'b1;
        fin_res  = rnd_res;
        fin_ovf  = rnd_ovf;
        fin_inx  = rnd_lost | rnd_ovf;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      sub_q     <= 1'b0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_q     <= '0;
      big_q     <= '0;
      small_q   <= '0;
      sum_q     <= '0;
      result    <= '0;
      ovf       <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        op_a_q <= a;
        op_b_q <= b;
        sub_q  <= op_sub;
      end
      if (state_q == ST_ALIGN) begin
        sign_q    <= sign_big;
        eff_sub_q <= sa ^ sb;
        exp_q     <= {1'b0, e_big};
        big_q     <= m_big;
        small_q   <= m_shift;
      end
      if (state_q == ST_ADD) sum_q <= sum_d;
      if (state_q == ST_NORM) begin
        if (sum_q[MW]) begin
          sum_q <= norm_right;
          exp_q <= exp_q + XW'(1);
        end else begin
          sum_q <= {sum_q[MW-1:0], 1'b0};
          exp_q <= exp_q - XW'(1);
        end
      end
      if (fin_load) begin
        result  <= fin_res;
        ovf     <= fin_ovf;
        inexact <= fin_inx;
      end
    end
  end

  assign done = (state_q == ST_DONE);
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_flt_addsub_seq.sv
// Scoreboard bench for flt_addsub_seq: directed vectors push expectations, a
// negedge monitor pops and compares on every done.
module tb_flt_addsub_seq;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        inx;
    int          lat;
    int          scyc;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, op_sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [15:0] result;
  logic        done, busy, ovf, inexact;

  logic        start8 = 1'b0, op_sub8 = 1'b0;
  logic [15:0] a8 = '0, b8 = '0;
  logic [15:0] result8;
  logic        done8, busy8, ovf8, inexact8;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q5[$];
  exp_t q8[$];
  exp_t m5, m8;

  flt_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .result(result), .done(done), .busy(busy), .ovf(ovf), .inexact(inexact)
  );

  flt_addsub_seq #(.EXP_W(8), .MAN_W(7)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op_sub(op_sub8), .a(a8), .b(b8),
    .result(result8), .done(done8), .busy(busy8), .ovf(ovf8), .inexact(inexact8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q5.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got result %h with nothing pending, expected no done", result);
      end else begin
        m5 = q5.pop_front();
        chk({m5.nm, " result"}, 32'(result), 32'(m5.res));
        chk({m5.nm, " ovf"}, 32'(ovf), 32'(m5.ovf));
        chk({m5.nm, " inexact"}, 32'(inexact), 32'(m5.inx));
        chk({m5.nm, " latency"}, 32'(cyc - m5.scyc + 1), 32'(m5.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done8: got result %h with nothing pending, expected no done", result8);
      end else begin
        m8 = q8.pop_front();
        chk({m8.nm, " result"}, 32'(result8), 32'(m8.res));
        chk({m8.nm, " ovf"}, 32'(ovf8), 32'(m8.ovf));
        chk({m8.nm, " inexact"}, 32'(inexact8), 32'(m8.inx));
        chk({m8.nm, " latency"}, 32'(cyc - m8.scyc + 1), 32'(m8.lat));
      end
    end
  end

  task automatic push5(input logic [15:0] er, input logic eo, input logic ei,
                       input int el, input string nm);
    exp_t e;
    e.res = er; e.ovf = eo; e.inx = ei; e.lat = el; e.scyc = cyc; e.nm = nm;
    q5.push_back(e);
  endtask

  // Waits for done with busy held, then checks the DUT is idle one cycle later.
  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    bit busy_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    chk({nm, " busy_held"}, 32'(busy_ok), 32'd1);
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: no done within 40 cycles, expected done", nm);
      q5.delete();
    end
    @(negedge clk);
    chk({nm, " idle_after"}, 32'({busy, done}), 32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic sub,
                       input logic [15:0] er, input logic eo, input logic ei,
                       input int el, input string nm);
    a = ta; b = tb; op_sub = sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push5(er, eo, ei, el, nm);
    wait_done(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst result", 32'(result), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    chk("rst inexact", 32'(inexact), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    issue(16'h3E00, 16'h3E00, 1'b0, 16'h4200, 1'b0, 1'b0, 6,  "add_carry");
    issue(16'h3C00, 16'h3BFF, 1'b1, 16'h1000, 1'b0, 1'b0, 16, "sub_k11");
    issue(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 1'b0, 1'b1, 5,  "tie_even");
    issue(16'h3C00, 16'h1200, 1'b0, 16'h3C01, 1'b0, 1'b1, 5,  "round_up");
    issue(16'h3C01, 16'h1000, 1'b0, 16'h3C02, 1'b0, 1'b1, 5,  "tie_odd");
    issue(16'h3FFF, 16'h1000, 1'b0, 16'h4000, 1'b0, 1'b1, 5,  "round_carry");
    issue(16'h3C00, 16'h0400, 1'b0, 16'h3C00, 1'b0, 1'b1, 5,  "sticky_only");
    issue(16'h3C00, 16'h4000, 1'b1, 16'hBC00, 1'b0, 1'b0, 6,  "sub_neg");
    issue(16'hC000, 16'h3C00, 1'b0, 16'hBC00, 1'b0, 1'b0, 6,  "mixed_sign");
    issue(16'h0401, 16'h0400, 1'b1, 16'h0000, 1'b0, 1'b1, 5,  "underflow");
    issue(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1'b0, 1'b0, 2,  "inf_minus_inf");
    issue(16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 1'b0, 1'b0, 2,  "nan_in");
    issue(16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 1'b0, 1'b0, 2,  "inf_op_x");
    issue(16'h0000, 16'h3C00, 1'b1, 16'hBC00, 1'b0, 1'b0, 2,  "zero_minus_x");
    issue(16'h0200, 16'h3C00, 1'b0, 16'h3C00, 1'b0, 1'b0, 2,  "subnorm_flush");
    issue(16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0, 2,  "negz_plus_negz");
    issue(16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b0, 1'b0, 2,  "negz_minus_negz");
    issue(16'h7BFF, 16'h4C00, 1'b0, 16'h7C00, 1'b1, 1'b1, 5,  "round_ovf");

    // Exact cancellation, with a stray start and input changes while busy.
    a = 16'h3C00; b = 16'h3C00; op_sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    push5(16'h0000, 1'b0, 1'b0, 4, "cancel_ignore");
    start = 1'b0; a = 16'h3E00; b = 16'h3E00; op_sub = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("cancel_ignore");

    issue(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b1, 6, "add_ovf");

    // Reset asserted during ALIGN abandons the operation.
    a = 16'h3E00; b = 16'h3E00; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst result", 32'(result), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst ovf", 32'(ovf), 32'd0);
    chk("midrst inexact", 32'(inexact), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    issue(16'h3E00, 16'h3E00, 1'b0, 16'h4200, 1'b0, 1'b0, 6, "after_reset");

    // Wider-exponent, narrower-mantissa instance: 1.5 + 1.5.
    a8 = 16'h3FC0; b8 = 16'h3FC0; op_sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    begin
      exp_t e;
      bit seen8 = 1'b0;
      e.res = 16'h4040; e.ovf = 1'b0; e.inx = 1'b0; e.lat = 6; e.scyc = cyc; e.nm = "e8m7_add";
      q8.push_back(e);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done8) begin
          seen8 = 1'b1;
          break;
        end
      end
      if (!seen8) begin
        n_cmp++;
        n_fail++;
        $display("FAIL e8m7_add timeout: no done within 40 cycles, expected done");
      end
    end
    repeat (3) @(negedge clk);

    chk("q5_drained", 32'(q5.size()), 32'd0);
    chk("q8_drained", 32'(q8.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
